// File: rtl/bus_slave_pkg.sv
// Shared types and constants for the bus_* serial slaves.
package bus_slave_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic TXD_IDLE = 1'b1;
endpackage

// File: rtl/bus_uart_tx_if.sv
// FIFO pop handshake between bus_fifo (master) and a serial consumer (slave).
interface bus_uart_tx_if #(parameter int width = 8) ();
    logic             DATA_READY;
    logic [width-1:0] DATA_IN;
    logic             DATA_ACK;

    modport master (output DATA_READY, output DATA_IN, input DATA_ACK);
    modport slave  (input DATA_READY, input DATA_IN, output DATA_ACK);
endinterface

// File: rtl/bus_baud_tick.sv
// Loadable bit-period counter: bit_end marks the last cycle of each bit period.
module bus_baud_tick #(
    parameter int div_width = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 load,
    input  logic                 run,
    input  logic [div_width-1:0] div,
    output logic                 bit_end
);
    logic [div_width-1:0] cnt;
    logic [div_width-1:0] div_q;

    // Equality compare keeps any div value, including all-ones, overflow-free.
    assign bit_end = run && (cnt == div_q);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            div_q <= div;
        end else if (run) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bus_uart_tx.sv
// UART-style transmitter that pops words from bus_fifo and serialises them LSB first.
module bus_uart_tx
    import bus_slave_pkg::*;
#(
    parameter int width     = 8,
    parameter int div_width = 16,
    parameter int stop_bits = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    bus_uart_tx_if.slave         fifo,
    input  logic [div_width-1:0] BAUD_DIV,
    output logic                 TXD,
    output logic                 BUSY
);
    localparam int BW = (width > 1) ? $clog2(width) : 1;

    tx_state_t        state;
    logic [width-1:0] shift;
    logic [BW-1:0]    bit_cnt;
    logic             stop_cnt;
    logic             bit_end;
    logic             load;
    logic             run;

    assign load = (state == IDLE) && fifo.DATA_READY;
    assign run  = (state != IDLE);

    bus_baud_tick #(.div_width(div_width)) u_tick (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .load    (load),
        .run     (run),
        .div     (BAUD_DIV),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state         <= IDLE;
            shift         <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            TXD           <= TXD_IDLE;
            BUSY          <= 1'b0;
            fifo.DATA_ACK <= 1'b0;
        end else begin
            fifo.DATA_ACK <= 1'b0;
            case (state)
                IDLE: if (fifo.DATA_READY) begin
                    state         <= START;
                    shift         <= fifo.DATA_IN;
                    bit_cnt       <= '0;
                    TXD           <= 1'b0;
                    BUSY          <= 1'b1;
                    fifo.DATA_ACK <= 1'b1;
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    TXD     <= shift[0];
                    bit_cnt <= '0;
                end
                DATA: if (bit_end) begin
                    if (bit_cnt == BW'(width - 1)) begin
                        state    <= STOP;
                        TXD      <= TXD_IDLE;
                        stop_cnt <= 1'b0;
                    end else begin
                        // shift[1] is the bit that lands in shift[0] after this edge
                        shift   <= {1'b0, shift[width-1:1]};
                        TXD     <= shift[1];
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: if (bit_end) begin
                    if (stop_cnt || stop_bits == 1) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: two instances (1 and 2 stop bits), each fed by a small FIFO model.
module tb_bus_uart_tx;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        txd1, busy1, txd2, busy2;

    bus_uart_tx_if #(.width(8)) f1 ();
    bus_uart_tx_if #(.width(8)) f2 ();

    logic [7:0] mem1 [0:15];
    logic [7:0] mem2 [0:15];
    int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;

    assign f1.DATA_READY = (wr1 != rd1);
    assign f1.DATA_IN    = mem1[rd1[3:0]];
    assign f2.DATA_READY = (wr2 != rd2);
    assign f2.DATA_IN    = mem2[rd2[3:0]];

    always @(posedge CLK) begin
        if (f1.DATA_ACK && wr1 != rd1) rd1 <= rd1 + 1;
        if (f2.DATA_ACK && wr2 != rd2) rd2 <= rd2 + 1;
    end

    bus_uart_tx #(.width(8), .div_width(16), .stop_bits(1)) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .fifo(f1.slave),
        .BAUD_DIV(baud_div), .TXD(txd1), .BUSY(busy1)
    );
    bus_uart_tx #(.width(8), .div_width(16), .stop_bits(2)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .fifo(f2.slave),
        .BAUD_DIV(baud_div), .TXD(txd2), .BUSY(busy2)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push1(input logic [7:0] v);
        mem1[wr1[3:0]] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic push2(input logic [7:0] v);
        mem2[wr2[3:0]] = v;
        wr2 = wr2 + 1;
    endtask

    function automatic logic ack_of(input int sel);
        return (sel == 2) ? f2.DATA_ACK : f1.DATA_ACK;
    endfunction

    // Advance until the selected DUT pulses DATA_ACK, bounded.
    task automatic wait_ack(input int sel, input string tag);
        int n = 0;
        while (!ack_of(sel) && n < 300) begin
            step();
            n++;
        end
        chk({tag, " ack seen"}, 64'(ack_of(sel)), 64'd1);
    endtask

    // Called at the sample right after the start edge; leaves at the sample after the frame.
    task automatic frame(input int sel, input int d, input int sb, input logic [15:0] seq,
                         input string tag);
        int nb = 1 + 8 + sb;
        logic [15:0] bits = '0;
        int glitch = 0, busy_n = 0, acks = 0;
        logic t;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c <= d; c++) begin
                t = (sel == 2) ? txd2 : txd1;
                if (c == 0) bits[b] = t;
                else if (t !== bits[b]) glitch++;
                busy_n += int'((sel == 2) ? busy2 : busy1);
                acks   += int'(ack_of(sel));
                step();
            end
        end
        chk({tag, " bits"}, 64'(bits), 64'(seq));
        chk({tag, " glitch"}, 64'(glitch), 64'd0);
        chk({tag, " busy cycles"}, 64'(busy_n), 64'(nb * (d + 1)));
        chk({tag, " ack pulses"}, 64'(acks), 64'd1);
        chk({tag, " end idle"},
            64'((sel == 2) ? {txd2, f2.DATA_ACK, busy2} : {txd1, f1.DATA_ACK, busy1}), 64'b100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        // Reset held with a word waiting: nothing moves until RESET_N rises.
        RESET_N  = 1'b0;
        baud_div = 16'd3;
        push1(8'hA5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset outs dut1", 64'({txd1, f1.DATA_ACK, busy1}), 64'b100);
            chk("reset outs dut2", 64'({txd2, f2.DATA_ACK, busy2}), 64'b100);
        end
        RESET_N = 1'b1;
        step();
        chk("first ack", 64'(f1.DATA_ACK), 64'd1);
        frame(1, 3, 1, 16'b1101001010, "a5");

        // Back-to-back words at one cycle per bit with a single idle gap.
        baud_div = 16'd0;
        push1(8'h00); push1(8'hFF); push1(8'h3C);
        step();
        chk("b2b ack0", 64'(f1.DATA_ACK), 64'd1);
        frame(1, 0, 1, 16'b1000000000, "w00");
        step();
        chk("gap ack1", 64'(f1.DATA_ACK), 64'd1);
        frame(1, 0, 1, 16'b1111111110, "wff");
        step();
        chk("gap ack2", 64'(f1.DATA_ACK), 64'd1);
        frame(1, 0, 1, 16'b1001111000, "w3c");
        chk("fifo empty", 64'(wr1 - rd1), 64'd0);

        // BAUD_DIV change during a frame only affects the following frame.
        baud_div = 16'd1;
        push1(8'h5A);
        wait_ack(1, "div1");
        baud_div = 16'd5;
        frame(1, 1, 1, 16'b1010110100, "w5a");
        push1(8'hC3);
        wait_ack(1, "div5");
        frame(1, 5, 1, 16'b1110000110, "wc3");

        // One-cycle reset in the middle of the data bits.
        baud_div = 16'd3;
        push1(8'h96);
        wait_ack(1, "pre rst");
        repeat (12) step();
        chk("mid data busy", 64'(busy1), 64'd1);
        RESET_N = 1'b0;
        step();
        chk("mid rst outs", 64'({txd1, f1.DATA_ACK, busy1}), 64'b100);
        RESET_N = 1'b1;
        a = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            a += int'(f1.DATA_ACK) + int'(busy1);
        end
        chk("no extra ack", 64'(a), 64'd0);
        chk("rst fifo empty", 64'(wr1 - rd1), 64'd0);
        push1(8'h81);
        wait_ack(1, "post rst");
        frame(1, 3, 1, 16'b1100000010, "w81");

        // Two stop bits.
        baud_div = 16'd1;
        push2(8'h01);
        wait_ack(2, "stop2");
        frame(2, 1, 2, 16'b0000011000000010, "w01 sb2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
